// File: rtl/sub_bytes_engine.sv
// Time-multiplexed AES byte substitution: LANES bytes per word pushed through
// UNITS shared forward/inverse S-box lookups, LANES/UNITS beats per word.
module sub_bytes_engine #(
  parameter int LANES  = 4,
  parameter int UNITS  = 4,
  parameter int INV_EN = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] in_data,
  input  logic               in_inv,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic               busy
);

  localparam int BEATS = LANES / UNITS;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  generate
    if ((LANES < 1) || (LANES > 16) || (UNITS < 1) || ((LANES % UNITS) != 0)) begin : g_bad_params
      $error("sub_bytes_engine: LANES must be 1..16 and a multiple of UNITS");
    end
  endgenerate

  // FIPS-197 tables, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] substitute(input logic [7:0] b, input logic use_inv);
    if (use_inv && (INV_EN != 0)) return SBOX_INV[8*(255 - int'(b)) +: 8];
    return SBOX_FWD[8*(255 - int'(b)) +: 8];
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      beat_q;
  logic [8*LANES-1:0] word_q;
  logic [8*LANES-1:0] sub_word;
  logic               mode_q;

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (beat_q == LAST_BEAT) state_d = DONE;
      end
      DONE: begin
        busy = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_valid = (state_q == DONE);

  // The word register with the current beat's UNITS bytes already substituted.
  always_comb begin
    sub_word = word_q;
    for (int u = 0; u < UNITS; u++) begin
      sub_word[8*(int'(beat_q)*UNITS + u) +: 8] =
        substitute(word_q[8*(int'(beat_q)*UNITS + u) +: 8], mode_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      word_q   <= '0;
      mode_q   <= 1'b0;
      out_data <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            word_q <= in_data;
            mode_q <= in_inv && (INV_EN != 0);
            beat_q <= '0;
          end
        end
        RUN: begin
          word_q <= sub_word;
          if (beat_q == LAST_BEAT) out_data <= sub_word;
          else                     beat_q   <= beat_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Self-checking bench for sub_bytes_engine: five parameterisations share one
// clock; expected words come from an algorithmic GF(2^8) S-box model.
module tb_sub_bytes_engine;

  localparam int N = 5;
  localparam int LANES_OF [N] = '{4, 4, 4, 16, 1};
  localparam int BEATS_OF [N] = '{1, 4, 1, 4, 1};
  localparam bit INVEN_OF [N] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid [N];
  logic [127:0] in_data;
  logic         in_inv;
  logic         out_ready;

  wire          in_ready_w  [N];
  wire          out_valid_w [N];
  wire          busy_w      [N];
  wire  [127:0] out_data_w  [N];
  wire  [31:0]  od0, od1, od2;
  wire  [127:0] od3;
  wire  [7:0]   od4;

  logic [7:0]   fwd_tab [256];
  logic [7:0]   inv_tab [256];
  logic [127:0] sb [$];
  int           tests = 0;
  int           fails = 0;

  always #5 clk = ~clk;

  sub_bytes_engine #(.LANES(4), .UNITS(4), .INV_EN(1)) u_l4u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready_w[0]),
    .in_data(in_data[31:0]), .in_inv(in_inv), .out_valid(out_valid_w[0]),
    .out_ready(out_ready), .out_data(od0), .busy(busy_w[0]));

  sub_bytes_engine #(.LANES(4), .UNITS(1), .INV_EN(1)) u_l4u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready_w[1]),
    .in_data(in_data[31:0]), .in_inv(in_inv), .out_valid(out_valid_w[1]),
    .out_ready(out_ready), .out_data(od1), .busy(busy_w[1]));

  sub_bytes_engine #(.LANES(4), .UNITS(4), .INV_EN(0)) u_l4u4_fwd (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready_w[2]),
    .in_data(in_data[31:0]), .in_inv(in_inv), .out_valid(out_valid_w[2]),
    .out_ready(out_ready), .out_data(od2), .busy(busy_w[2]));

  sub_bytes_engine #(.LANES(16), .UNITS(4), .INV_EN(1)) u_l16u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready_w[3]),
    .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid_w[3]),
    .out_ready(out_ready), .out_data(od3), .busy(busy_w[3]));

  sub_bytes_engine #(.LANES(1), .UNITS(1), .INV_EN(1)) u_l1u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[4]), .in_ready(in_ready_w[4]),
    .in_data(in_data[7:0]), .in_inv(in_inv), .out_valid(out_valid_w[4]),
    .out_ready(out_ready), .out_data(od4), .busy(busy_w[4]));

  assign out_data_w[0] = {96'b0, od0};
  assign out_data_w[1] = {96'b0, od1};
  assign out_data_w[2] = {96'b0, od2};
  assign out_data_w[3] = od3;
  assign out_data_w[4] = {120'b0, od4};

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [15:0] t;
    t = {v, v} << n;
    return t[15:8];
  endfunction

  // S(a) = affine(a^-1), with 0 mapping to itself before the affine step.
  task automatic build_tables();
    logic [7:0] x;
    for (int a = 0; a < 256; a++) begin
      x = 8'h00;
      for (int c = 1; c < 256; c++)
        if (a != 0 && gmul(8'(a), 8'(c)) == 8'h01) x = 8'(c);
      fwd_tab[a] = x ^ rotl(x, 1) ^ rotl(x, 2) ^ rotl(x, 3) ^ rotl(x, 4) ^ 8'h63;
    end
    for (int a = 0; a < 256; a++) inv_tab[fwd_tab[a]] = 8'(a);
  endtask

  function automatic logic [127:0] model(input logic [127:0] d, input int lanes,
                                         input bit inv, input bit inv_en);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < lanes; i++)
      r[8*i +: 8] = (inv && inv_en) ? inv_tab[d[8*i +: 8]] : fwd_tab[d[8*i +: 8]];
    return r;
  endfunction

  // Caller is positioned at a negedge; returns at the negedge where out_valid is first seen.
  task automatic run_word(input int idx, input logic [127:0] d, input bit inv,
                          input bit toggle, output logic [127:0] obs, output time t_acc);
    int         cyc;
    int         wait_n;
    bit         busy_bad;
    logic [127:0] exp_w;
    wait_n = 0;
    while (in_ready_w[idx] !== 1'b1 && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    tests++;
    if (in_ready_w[idx] !== 1'b1) begin
      fails++;
      $display("[TB] FAIL accept_wait[%0d]: in_ready=%b, required 1", idx, in_ready_w[idx]);
    end
    in_data       = d;
    in_inv        = inv;
    in_valid[idx] = 1'b1;
    sb.push_back(model(d, LANES_OF[idx], inv, INVEN_OF[idx]));
    @(posedge clk);
    t_acc = $time;
    #1;
    in_valid[idx] = 1'b0;
    if (toggle) begin
      in_data = '1;
      in_inv  = ~inv;
    end
    cyc      = -1;
    busy_bad = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
      if (busy_w[idx] !== 1'b1) busy_bad = 1'b1;
    end while (out_valid_w[idx] !== 1'b1 && cyc < 40);
    tests++;
    if (cyc != BEATS_OF[idx]) begin
      fails++;
      $display("[TB] FAIL latency[%0d]: got %0d cycles, required %0d", idx, cyc, BEATS_OF[idx]);
    end
    tests++;
    if (busy_bad) begin
      fails++;
      $display("[TB] FAIL busy[%0d]: busy dropped during RUN/DONE, required 1 throughout", idx);
    end
    exp_w = sb.pop_front();
    obs   = out_data_w[idx];
    tests++;
    if (obs !== exp_w) begin
      fails++;
      $display("[TB] FAIL data[%0d]: got %h, required %h", idx, obs, exp_w);
    end
  endtask

  task automatic check_idle(input string tag, input int idx, input logic [127:0] exp_od);
    tests++;
    if (in_ready_w[idx] !== 1'b1 || out_valid_w[idx] !== 1'b0 || busy_w[idx] !== 1'b0 ||
        out_data_w[idx] !== exp_od) begin
      fails++;
      $display("[TB] FAIL %s[%0d]: ready=%b valid=%b busy=%b data=%h, required 1 0 0 %h",
               tag, idx, in_ready_w[idx], out_valid_w[idx], busy_w[idx], out_data_w[idx], exp_od);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_data   = '0;
    in_inv    = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) in_valid[i] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) check_idle("reset", i, '0);
  endtask

  task automatic test_single_beat();
    logic [127:0] obs;
    time          t;
    out_ready = 1'b1;
    run_word(0, 128'hFF530100, 1'b0, 1'b0, obs, t);
    tests++;
    if (obs[31:0] !== 32'h16ED7C63) begin
      fails++;
      $display("[TB] FAIL single_const: got %h, required 16ed7c63", obs[31:0]);
    end
    tests++;
    if (in_ready_w[0] !== 1'b0) begin
      fails++;
      $display("[TB] FAIL single_done_ready: in_ready=%b, required 0", in_ready_w[0]);
    end
    @(negedge clk);
    check_idle("single_back_idle", 0, 128'h16ED7C63);
  endtask

  task automatic test_multi_beat();
    logic [127:0] obs;
    time          t;
    out_ready = 1'b1;
    run_word(1, 128'hFF530100, 1'b0, 1'b1, obs, t);
    tests++;
    if (obs[31:0] !== 32'h16ED7C63) begin
      fails++;
      $display("[TB] FAIL multi_const: got %h, required 16ed7c63", obs[31:0]);
    end
    @(negedge clk);
  endtask

  task automatic test_inverse();
    logic [127:0] obs;
    time          t;
    out_ready = 1'b1;
    run_word(0, 128'h16ED7C63, 1'b1, 1'b0, obs, t);
    tests++;
    if (obs[31:0] !== 32'hFF530100) begin
      fails++;
      $display("[TB] FAIL inverse_const: got %h, required ff530100", obs[31:0]);
    end
    @(negedge clk);
    run_word(2, 128'h16ED7C63, 1'b1, 1'b0, obs, t);
    tests++;
    if (obs[31:0] !== 32'h475510FB) begin
      fails++;
      $display("[TB] FAIL inv_disabled_const: got %h, required 475510fb", obs[31:0]);
    end
    @(negedge clk);
  endtask

  task automatic test_back_pressure();
    logic [127:0] obs;
    time          t;
    out_ready = 1'b0;
    run_word(0, 128'hA5C3_0F1E, 1'b0, 1'b0, obs, t);
    in_data     = 128'h1234_5678;
    in_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if (out_data_w[0] !== obs || out_valid_w[0] !== 1'b1 || in_ready_w[0] !== 1'b0) begin
        fails++;
        $display("[TB] FAIL hold[%0d]: data=%h valid=%b ready=%b, required %h 1 0",
                 i, out_data_w[0], out_valid_w[0], in_ready_w[0], obs);
      end
    end
    in_valid[0] = 1'b0;
    out_ready   = 1'b1;
    @(negedge clk);
    check_idle("bp_release", 0, obs);
  endtask

  task automatic test_wide();
    logic [127:0] obs;
    time          t;
    out_ready = 1'b1;
    run_word(3, 128'h0F0E0D0C0B0A09080706050403020100, 1'b0, 1'b0, obs, t);
    tests++;
    if (obs !== 128'h76ABD7FE2B670130C56F6BF27B777C63) begin
      fails++;
      $display("[TB] FAIL wide_const: got %h, required 76abd7fe2b670130c56f6bf27b777c63", obs);
    end
    @(negedge clk);
    run_word(3, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0, obs, t);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [127:0] obs;
    time          t_prev, t_now;
    out_ready = 1'b1;
    run_word(1, 128'($urandom), 1'b0, 1'b0, obs, t_prev);
    for (int k = 0; k < 3; k++) begin
      run_word(1, 128'($urandom), 1'($urandom_range(0, 1)), 1'b0, obs, t_now);
      tests++;
      if (t_now - t_prev != 60) begin
        fails++;
        $display("[TB] FAIL spacing[%0d]: got %0t, required 60", k, t_now - t_prev);
      end
      t_prev = t_now;
    end
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      run_word(4, 128'($urandom_range(0, 255)), 1'(k % 2), 1'b0, obs, t_now);
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [127:0] obs;
    time          t;
    out_ready   = 1'b1;
    in_data     = 128'hDEADBEEF;
    in_valid[1] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[1] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("mid_reset", 1, '0);
    run_word(1, 128'h0102_0304, 1'b0, 1'b0, obs, t);
    @(negedge clk);
    rst         = 1'b1;
    in_valid[0] = 1'b1;
    in_data     = 128'h1111_1111;
    @(negedge clk);
    rst         = 1'b0;
    in_valid[0] = 1'b0;
    check_idle("reset_vs_valid", 0, '0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    build_tables();
    test_reset();
    test_single_beat();
    test_multi_beat();
    test_inverse();
    test_back_pressure();
    test_wide();
    test_back_to_back();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
